// File: rtl/arith_op_sequencer.sv
// arith_op_sequencer: issues one op per command to the arithmetic unit and holds its result on a valid/ready port
// Optional DIV_ZERO_CHECK_EN traps fun[1:0]=2'b11 with b=0 locally instead of issuing it.
module arith_op_sequencer #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd_fun,
  input  logic [WIDTH-1:0]     cmd_a,
  input  logic [WIDTH-1:0]     cmd_b,
  output logic                 Arith_EN,
  output logic [3:0]           alu_fun,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     Arith_out,
  input  logic                 Carry_out,
  input  logic                 Arith_flag,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [WIDTH-1:0]     res_data,
  output logic                 res_carry,
  output logic                 res_err,
  output logic [CNT_WIDTH-1:0] op_cnt
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
  state_t state, state_n;
  logic div_zero, accept;
`ifdef DIV_ZERO_CHECK_EN
  assign div_zero = cmd_fun[1:0] == 2'b11 && cmd_b == '0;
`else
  assign div_zero = 1'b0;
`endif
  assign cmd_ready = state == IDLE;
  assign res_valid = state == HOLD;
  assign accept    = cmd_ready && cmd_valid;
  always_comb begin
    state_n = state;
    state_n = accept ? (div_zero ? HOLD : ISSUE) :
              state == ISSUE ? WAIT :
              state == WAIT ? HOLD :
              (state == HOLD && res_ready) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      Arith_EN  <= 1'b0;
      alu_fun   <= '0;
      a         <= '0;
      b         <= '0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_err   <= 1'b0;
      op_cnt    <= '0;
    end else begin
      state    <= state_n;
      Arith_EN <= state_n == ISSUE;
      if (accept && !div_zero) begin
        alu_fun <= cmd_fun;
        a       <= cmd_a;
        b       <= cmd_b;
      end
      // the unit's registered outputs are valid during WAIT, one cycle after Arith_EN
      if (state == WAIT) begin
        res_data  <= Arith_out;
        res_carry <= Carry_out;
        res_err   <= ~Arith_flag;
      end
      if (accept && div_zero) begin
        res_data  <= '1;
        res_carry <= 1'b0;
        res_err   <= 1'b1;
      end
      if (state == HOLD && res_ready) op_cnt <= op_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_arith_op_sequencer.sv
// tb_arith_op_sequencer: directed checks of the sequencer against a registered arithmetic unit model
module tb_arith_op_sequencer;
  logic clk = 0, rst_n = 0;
  logic cmd_valid = 0, cmd_ready;
  logic [3:0] cmd_fun = 0;
  logic [15:0] cmd_a = 0, cmd_b = 0;
  logic Arith_EN;
  logic [3:0] alu_fun;
  logic [15:0] a, b;
  logic [15:0] Arith_out = 0;
  logic Carry_out = 0, Arith_flag = 0;
  logic res_valid, res_ready = 0;
  logic [15:0] res_data;
  logic res_carry, res_err;
  logic [7:0] op_cnt;
  logic kill = 0;
  logic [31:0] prod;
  int vecs = 0, errs = 0, en_cnt = 0;

  arith_op_sequencer #(.WIDTH(16), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_fun(cmd_fun), .cmd_a(cmd_a), .cmd_b(cmd_b), .Arith_EN(Arith_EN),
    .alu_fun(alu_fun), .a(a), .b(b), .Arith_out(Arith_out), .Carry_out(Carry_out),
    .Arith_flag(Arith_flag), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_carry(res_carry), .res_err(res_err), .op_cnt(op_cnt)
  );

  always #5 clk = ~clk;

  assign prod = {16'h0, a} * {16'h0, b};
  always_ff @(posedge clk) begin
    Arith_flag <= Arith_EN & ~kill;
    if (Arith_EN) begin
      en_cnt <= en_cnt + 1;
      case (alu_fun[1:0])
        2'd0: {Carry_out, Arith_out} <= {1'b0, a} + {1'b0, b};
        2'd1: {Carry_out, Arith_out} <= {1'b0, a} - {1'b0, b};
        2'd2: begin Arith_out <= prod[15:0]; Carry_out <= |prod[31:16]; end
        default: begin Arith_out <= (b == 0) ? 16'h0 : a / b; Carry_out <= 1'b0; end
      endcase
    end
  end

  task automatic send(input logic [3:0] f, input logic [15:0] x, input logic [15:0] y);
    cmd_fun = f; cmd_a = x; cmd_b = y; cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic finish_op();
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
  endtask

  task automatic test_reset_init();
    repeat (2) @(negedge clk);
    rst_n = 1;
    vecs++; if ({Arith_EN, alu_fun, a, b} !== 37'h0) begin errs++; $display("FAIL init_issue got %h exp 0", {Arith_EN, alu_fun, a, b}); end
    vecs++; if ({res_valid, res_data, res_carry, res_err, op_cnt} !== 27'h0) begin errs++; $display("FAIL init_res got %h exp 0", {res_valid, res_data, res_carry, res_err, op_cnt}); end
    vecs++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL init_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_add();
    send(4'h0, 16'hFFFF, 16'h0002);
    vecs++; if ({Arith_EN, alu_fun, a, b, cmd_ready} !== {1'b1, 4'h0, 16'hFFFF, 16'h0002, 1'b0}) begin errs++; $display("FAIL add_issue got %h", {Arith_EN, alu_fun, a, b, cmd_ready}); end
    @(negedge clk);
    vecs++; if ({Arith_EN, res_valid} !== 2'b00) begin errs++; $display("FAIL add_wait got %b exp 00", {Arith_EN, res_valid}); end
    @(negedge clk);
    vecs++; if ({res_valid, res_data, res_carry, res_err, op_cnt} !== {1'b1, 16'h0001, 1'b1, 1'b0, 8'd0}) begin errs++; $display("FAIL add_hold got %h", {res_valid, res_data, res_carry, res_err, op_cnt}); end
    finish_op();
    vecs++; if ({res_valid, cmd_ready, op_cnt} !== {1'b0, 1'b1, 8'd1}) begin errs++; $display("FAIL add_done got %h exp 101", {res_valid, cmd_ready, op_cnt}); end
  endtask

  task automatic test_backpressure();
    send(4'h1, 16'd10, 16'd3);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      vecs++; if ({res_valid, res_data, res_carry, res_err, cmd_ready, Arith_EN, a} !== {1'b1, 16'd7, 1'b0, 1'b0, 1'b0, 1'b0, 16'd10}) begin errs++; $display("FAIL bp_hold%0d got %h", i, {res_valid, res_data, res_carry, res_err, cmd_ready, Arith_EN, a}); end
      cmd_valid = i[0]; cmd_fun = 4'h2; cmd_a = 16'h1234; cmd_b = 16'h0042;
      @(negedge clk);
    end
    cmd_valid = 0;
    vecs++; if ({res_valid, Arith_EN, a} !== {1'b1, 1'b0, 16'd10}) begin errs++; $display("FAIL bp_ignored got %h", {res_valid, Arith_EN, a}); end
    finish_op();
    vecs++; if ({res_valid, cmd_ready, op_cnt} !== {1'b0, 1'b1, 8'd2}) begin errs++; $display("FAIL bp_done got %h exp 102", {res_valid, cmd_ready, op_cnt}); end
  endtask

  task automatic test_flag_err();
    kill = 1;
    send(4'h0, 16'd5, 16'd6);
    repeat (2) @(negedge clk);
    kill = 0;
    vecs++; if ({res_valid, res_data, res_err} !== {1'b1, 16'd11, 1'b1}) begin errs++; $display("FAIL flag_err got %h", {res_valid, res_data, res_err}); end
    finish_op();
  endtask

  task automatic test_div_zero();
    send(4'h3, 16'd100, 16'd0);
`ifdef DIV_ZERO_CHECK_EN
    vecs++; if ({Arith_EN, res_valid, res_data, res_carry, res_err} !== {1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1}) begin errs++; $display("FAIL div0_trap got %h", {Arith_EN, res_valid, res_data, res_carry, res_err}); end
`else
    vecs++; if ({Arith_EN, res_valid} !== 2'b10) begin errs++; $display("FAIL div0_issue got %b exp 10", {Arith_EN, res_valid}); end
    repeat (2) @(negedge clk);
    vecs++; if ({res_valid, res_data, res_err} !== {1'b1, 16'h0000, 1'b0}) begin errs++; $display("FAIL div0_res got %h", {res_valid, res_data, res_err}); end
`endif
    finish_op();
    vecs++; if ({cmd_ready, op_cnt} !== {1'b1, 8'd4}) begin errs++; $display("FAIL div0_done got %h exp 104", {cmd_ready, op_cnt}); end
  endtask

  task automatic test_reset();
    send(4'h0, 16'd1, 16'd1);
    @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    vecs++; if ({Arith_EN, alu_fun, a, b} !== 37'h0) begin errs++; $display("FAIL rst_issue got %h exp 0", {Arith_EN, alu_fun, a, b}); end
    vecs++; if ({res_valid, res_data, res_carry, res_err, op_cnt, cmd_ready} !== 28'h1) begin errs++; $display("FAIL rst_res got %h exp 1", {res_valid, res_data, res_carry, res_err, op_cnt, cmd_ready}); end
    repeat (3) @(negedge clk);
    vecs++; if ({res_valid, Arith_EN, cmd_ready} !== 3'b001) begin errs++; $display("FAIL rst_discard got %b exp 001", {res_valid, Arith_EN, cmd_ready}); end
  endtask

  task automatic test_back_to_back();
    int en0, t0;
    en0 = en_cnt;
    t0 = $time;
    res_ready = 1;
    for (int i = 0; i < 256; i++) begin
      vecs++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready%0d got %b exp 1", i, cmd_ready); end
      send(4'h2, 16'(i), 16'd3);
      repeat (2) @(negedge clk);
      vecs++; if ({res_valid, res_data, op_cnt} !== {1'b1, 16'(i * 3), 8'(i)}) begin errs++; $display("FAIL b2b_res%0d got %h exp %h", i, {res_valid, res_data, op_cnt}, {1'b1, 16'(i * 3), 8'(i)}); end
      @(negedge clk);
    end
    res_ready = 0;
    vecs++; if (op_cnt !== 8'd0) begin errs++; $display("FAIL b2b_wrap got %0d exp 0", op_cnt); end
    vecs++; if (en_cnt - en0 !== 256) begin errs++; $display("FAIL b2b_en_pulses got %0d exp 256", en_cnt - en0); end
    vecs++; if (($time - t0) !== 64'd10240) begin errs++; $display("FAIL b2b_time got %0t exp 10240", $time - t0); end
  endtask

  initial begin
    @(negedge clk);
    test_reset_init();
    test_add();
    test_backpressure();
    test_flag_err();
    test_div_zero();
    test_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
